// File: rtl/irq_seq_pkg.sv
// Shared core package: MIE bit indices, interrupt sequencer state encoding,
// machine-interrupt cause codes and mtvec mode encodings.
package irq_seq_pkg;

  // MIE / MIP bit positions for the machine-level interrupt sources
  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  // Interrupt sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_TRAP    = 2'd2,
    ST_HANDLER = 2'd3
  } irq_state_e;

  // Machine interrupt cause codes (low bits of mcause)
  localparam logic [3:0] CAUSE_EXT  = 4'd11;
  localparam logic [3:0] CAUSE_SOFT = 4'd3;
  localparam logic [3:0] CAUSE_TMR  = 4'd7;

  // mtvec[1:0] mode field
  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // Base address of the trap vector table (mode bits stripped)
  function automatic logic [31:0] trap_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/irq_seq_prio_enc.sv
// Fixed-priority encoder for the three machine interrupt sources:
// external > software > timer.
module irq_prio_enc
  import irq_seq_pkg::*;
(
  input  logic       ext_req,
  input  logic       soft_req,
  input  logic       tmr_req,
  output logic [3:0] code,
  output logic       valid
);

  // Pick the highest-priority active request
  always_comb begin
    code  = 4'd0;
    valid = 1'b0;
    if (ext_req) begin
      code  = CAUSE_EXT;
      valid = 1'b1;
    end else if (soft_req) begin
      code  = CAUSE_SOFT;
      valid = 1'b1;
    end else if (tmr_req) begin
      code  = CAUSE_TMR;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/irq_seq.sv
// Interrupt entry sequencer: holds fetch while the pipeline drains, then
// issues a single-cycle trap (flush, redirect, CSR write, ack) and tracks
// handler residency until MRET.
// Optional feature macro: IRQ_SEQ_VECTORED_EN enables vectored mtvec mode.
module irq_seq
  import irq_seq_pkg::*;
#(
  parameter int DRAIN_MAX = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        extern_irq_taken,
  input  logic        soft_irq_taken,
  input  logic        timer_irq_taken,
  input  logic        pipe_idle,
  input  logic [31:0] commit_pc,
  input  logic [31:0] mtvec,
  input  logic        is_mret,
  output logic        irq_ack,
  output logic        stall_fetch,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        csr_trap_we,
  output logic [31:0] csr_mcause,
  output logic [31:0] csr_mepc,
  output logic        in_handler,
  output logic        drain_timeout
);

  localparam logic [7:0] DRAIN_MAX_C = 8'(DRAIN_MAX);

  irq_state_e state_q, state_d;
  logic [3:0] code_q,  code_d;
  logic [7:0] drain_q, drain_d;

  logic [3:0] enc_code;
  logic       enc_valid;

  irq_prio_enc u_prio_enc (
    .ext_req  (extern_irq_taken),
    .soft_req (soft_irq_taken),
    .tmr_req  (timer_irq_taken),
    .code     (enc_code),
    .valid    (enc_valid)
  );

  // State, latched cause and drain counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      code_q  <= 4'd0;
      drain_q <= 8'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; the drain counter holds the number of HOLD cycles
  // including the current one, so entry into HOLD loads 1
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    drain_d = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d = ST_HOLD;
          code_d  = enc_code;
          drain_d = 8'd1;
        end
      end
      ST_HOLD: begin
        if (!enc_valid) begin
          state_d = ST_IDLE;
        end else begin
          code_d = enc_code;
          if (pipe_idle) begin
            state_d = ST_TRAP;
          end else if (drain_q != DRAIN_MAX_C) begin
            drain_d = drain_q + 8'd1;
          end else begin
            drain_d = drain_q;
          end
        end
      end
      ST_TRAP: begin
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        // MRET wins over a simultaneous nested request
        if (is_mret) begin
          state_d = ST_IDLE;
        end else if (enc_valid) begin
          state_d = ST_HOLD;
          code_d  = enc_code;
          drain_d = 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic [31:0] trap_target;

`ifdef IRQ_SEQ_VECTORED_EN
  // Vectored mode offsets the base by 4 * cause; any other mode is direct
  always_comb begin
    trap_target = trap_base(mtvec);
    if (mtvec[1:0] == MTVEC_MODE_VECTORED) begin
      trap_target = trap_base(mtvec) + {26'd0, code_q, 2'b00};
    end
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];

  // Direct mode only: mtvec mode bits are ignored
  always_comb begin
    trap_target = trap_base(mtvec);
  end
`endif

  // Outputs are decoded from the current state so reset clears them at once
  always_comb begin
    irq_ack        = 1'b0;
    stall_fetch    = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    csr_trap_we    = 1'b0;
    csr_mcause     = 32'd0;
    csr_mepc       = 32'd0;
    in_handler     = 1'b0;
    drain_timeout  = 1'b0;
    case (state_q)
      ST_HOLD: begin
        stall_fetch   = 1'b1;
        drain_timeout = (drain_q == DRAIN_MAX_C);
      end
      ST_TRAP: begin
        stall_fetch    = 1'b1;
        irq_ack        = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = trap_target;
        csr_trap_we    = 1'b1;
        csr_mcause     = {1'b1, 27'd0, code_q};
        csr_mepc       = commit_pc;
      end
      ST_HANDLER: begin
        in_handler = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_irq_seq.sv
// Self-checking bench for irq_seq: directed table, corner-case sequences and
// randomized traffic against a behavioural model.
module tb_irq_seq;

  localparam int DRAIN_MAX = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        extern_irq_taken, soft_irq_taken, timer_irq_taken;
  logic        pipe_idle, is_mret;
  logic [31:0] commit_pc, mtvec;
  logic        irq_ack, stall_fetch, flush, redirect_valid, csr_trap_we;
  logic        in_handler, drain_timeout;
  logic [31:0] redirect_pc, csr_mcause, csr_mepc;

  irq_seq #(.DRAIN_MAX(DRAIN_MAX)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .extern_irq_taken (extern_irq_taken),
    .soft_irq_taken   (soft_irq_taken),
    .timer_irq_taken  (timer_irq_taken),
    .pipe_idle        (pipe_idle),
    .commit_pc        (commit_pc),
    .mtvec            (mtvec),
    .is_mret          (is_mret),
    .irq_ack          (irq_ack),
    .stall_fetch      (stall_fetch),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .csr_trap_we      (csr_trap_we),
    .csr_mcause       (csr_mcause),
    .csr_mepc         (csr_mepc),
    .in_handler       (in_handler),
    .drain_timeout    (drain_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: what the sequencer is doing, not how it encodes it
  bit m_waiting;   // fetch stalled, waiting for the pipeline to drain
  bit m_trapping;  // trap being taken this cycle
  bit m_handling;  // running the handler
  int m_hold;      // HOLD cycles so far, including the current one
  int m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_target();
    logic [31:0] r;
    r = mtvec & ~32'd3;
`ifdef IRQ_SEQ_VECTORED_EN
    if (mtvec[1:0] == 2'b01) r = r + 32'(m_cause * 4);
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_trapping = 0; m_handling = 0; m_hold = 0; m_cause = 0;
  endtask

  task automatic check_model();
    chk("stall_fetch",    {31'd0, stall_fetch},    {31'd0, m_waiting | m_trapping});
    chk("irq_ack",        {31'd0, irq_ack},        {31'd0, m_trapping});
    chk("flush",          {31'd0, flush},          {31'd0, m_trapping});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_trapping});
    chk("csr_trap_we",    {31'd0, csr_trap_we},    {31'd0, m_trapping});
    chk("in_handler",     {31'd0, in_handler},     {31'd0, m_handling});
    chk("drain_timeout",  {31'd0, drain_timeout},  {31'd0, m_waiting && (m_hold >= DRAIN_MAX)});
    chk("csr_mcause", csr_mcause, m_trapping ? (32'h8000_0000 | 32'(m_cause)) : 32'd0);
    chk("csr_mepc",   csr_mepc,   m_trapping ? commit_pc : 32'd0);
    chk("redirect_pc", redirect_pc, m_trapping ? exp_target() : 32'd0);
  endtask

  // Advance the model across the coming rising edge using current inputs
  task automatic model_step();
    bit any;
    int pri;
    any = extern_irq_taken | soft_irq_taken | timer_irq_taken;
    pri = extern_irq_taken ? 11 : soft_irq_taken ? 3 : timer_irq_taken ? 7 : 0;
    if (m_trapping) begin
      m_trapping = 0;
      m_handling = 1;
    end else if (m_handling) begin
      if (is_mret) m_handling = 0;
      else if (any) begin
        m_handling = 0; m_waiting = 1; m_hold = 1; m_cause = pri;
      end
    end else if (m_waiting) begin
      if (!any) begin
        m_waiting = 0; m_hold = 0;
      end else begin
        m_cause = pri;
        if (pipe_idle) begin
          m_waiting = 0; m_hold = 0; m_trapping = 1;
        end else m_hold++;
      end
    end else if (any) begin
      m_waiting = 1; m_hold = 1; m_cause = pri;
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, advance the model
  task automatic step(input logic e, input logic s, input logic t,
                      input logic idle, input logic mret, input logic [31:0] pc);
    @(negedge clk);
    extern_irq_taken = e; soft_irq_taken = s; timer_irq_taken = t;
    pipe_idle = idle; is_mret = mret; commit_pc = pc;
    #1;
    check_model();
    model_step();
  endtask

  typedef struct {
    logic        e, s, t, idle, mret;
    logic [31:0] pc;
    logic        stall, ack, ih;
    logic [31:0] mcause, redir;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h108, 1'b1, 1'b1, 1'b0, 32'h8000_0007, 32'h2000};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10c, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h110, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h114, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    extern_irq_taken = 0; soft_irq_taken = 0; timer_irq_taken = 0;
    pipe_idle = 0; is_mret = 0; commit_pc = 32'h0; mtvec = 32'h0000_2003;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    model_reset();
    #1 check_model();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Timer interrupt with an idle pipeline (direct, mode bits 11 ignored)
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].e, tbl[i].s, tbl[i].t, tbl[i].idle, tbl[i].mret, tbl[i].pc);
      chk($sformatf("tbl%0d.stall", i), {31'd0, stall_fetch}, {31'd0, tbl[i].stall});
      chk($sformatf("tbl%0d.ack", i),   {31'd0, irq_ack},     {31'd0, tbl[i].ack});
      chk($sformatf("tbl%0d.ih", i),    {31'd0, in_handler},  {31'd0, tbl[i].ih});
      chk($sformatf("tbl%0d.mcause", i), csr_mcause, tbl[i].mcause);
      chk($sformatf("tbl%0d.redir", i),  redirect_pc, tbl[i].redir);
    end

    // Soft request overtaken by extern while draining
    step(0, 1, 0, 0, 0, 32'h200);
    step(0, 1, 0, 0, 0, 32'h200);
    step(0, 1, 0, 0, 0, 32'h200);
    step(1, 1, 0, 0, 0, 32'h200);
    step(1, 1, 0, 0, 0, 32'h200);
    step(1, 1, 0, 0, 0, 32'h200);
    step(1, 1, 0, 1, 0, 32'h200);
    step(0, 0, 0, 1, 0, 32'h204);
    chk("nest_prio.mcause", csr_mcause, 32'h8000_000B);
    chk("nest_prio.mepc",   csr_mepc,   32'h204);
    step(0, 0, 0, 1, 1, 32'h0);
    step(0, 0, 0, 1, 0, 32'h0);

    // Vectored vs direct target for an extern request
    mtvec = 32'h0000_1001;
    step(1, 0, 0, 1, 0, 32'h300);
    step(1, 0, 0, 1, 0, 32'h300);
    step(0, 0, 0, 1, 0, 32'h300);
`ifdef IRQ_SEQ_VECTORED_EN
    chk("vec.redirect", redirect_pc, 32'h0000_102C);
`else
    chk("vec.redirect", redirect_pc, 32'h0000_1000);
`endif
    step(0, 0, 0, 1, 1, 32'h0);
    step(0, 0, 0, 1, 0, 32'h0);
    mtvec = 32'h0000_2003;

    // Drain timeout after DRAIN_MAX HOLD cycles, then a normal trap
    step(0, 0, 1, 0, 0, 32'h400);
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 1, 0, 0, 32'h400);
      chk($sformatf("drain.k%0d", k), {31'd0, drain_timeout}, {31'd0, k >= DRAIN_MAX});
    end
    step(0, 0, 1, 1, 0, 32'h404);
    chk("drain.still", {31'd0, drain_timeout}, 32'd1);
    step(0, 0, 0, 1, 0, 32'h408);
    chk("drain.trap_ack", {31'd0, irq_ack}, 32'd1);
    chk("drain.trap_dto", {31'd0, drain_timeout}, 32'd0);
    step(0, 0, 0, 1, 1, 32'h0);
    step(0, 0, 0, 1, 0, 32'h0);

    // MRET beats a simultaneous nested request
    step(1, 0, 0, 1, 0, 32'h500);
    step(1, 0, 0, 1, 0, 32'h500);
    step(0, 0, 0, 1, 0, 32'h500);
    step(0, 0, 0, 1, 0, 32'h0);
    step(1, 0, 0, 1, 1, 32'h0);
    step(1, 0, 0, 1, 0, 32'h0);
    chk("mret.idle_stall", {31'd0, stall_fetch}, 32'd0);
    chk("mret.idle_ih",    {31'd0, in_handler},  32'd0);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("mret.hold_stall", {31'd0, stall_fetch}, 32'd1);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);

    // Reset during TRAP drops the trap
    step(0, 0, 1, 1, 0, 32'h600);
    step(0, 0, 1, 1, 0, 32'h600);
    step(0, 0, 0, 1, 0, 32'h600);
    chk("rst.trap_ack", {31'd0, irq_ack}, 32'd1);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check_model();
    chk("rst.async_ack",    {31'd0, irq_ack},     32'd0);
    chk("rst.async_mepc",   csr_mepc,             32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 0, 32'h0);
      chk($sformatf("rst.noack%0d", k), {31'd0, irq_ack}, 32'd0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) mtvec = $urandom;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
